load_store_unit: RTL

Parametrised load/store unit for the MEM stage of the RV CPU core. It replaces fixed low-byte load extraction with address-offset byte-lane alignment for loads and stores, and adds store byte enables, misalignment and illegal-op detection, and a req/gnt/rvalid handshake to data memory with a bus timeout. It sits between the EX/MEM pipeline register and the data memory port and returns one registered response per accepted request.

---
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: lane alignment, byte enables, misalign/illegal
// detection and a req/gnt/rvalid data-memory handshake with bus timeout.
//
// state  | meaning
// S_IDLE | ready for a new request
// S_REQ  | o_mem_req held until grant
// S_WAIT | load granted, waiting for read data
// S_RESP | one-cycle response with error flags
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [6:0]                i_opcode,
  input  logic [2:0]                i_func3,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH/8-1:0]   o_mem_be,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic                      i_mem_gnt,
  input  logic                      i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
  output logic                      o_rsp_valid,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic                      o_err_misalign,
  output logic                      o_err_bus,
  output logic                      o_err_illegal
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam logic WIDE = 1'(DATA_WIDTH == 64);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            func3_q, func3_d;
  logic [OFS-1:0]        ofs_q, ofs_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB-1:0]         be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_mis_q, err_mis_d;
  logic                  err_bus_q, err_bus_d;
  logic                  err_ill_q, err_ill_d;
  logic [7:0]            tmo_q, tmo_d;

  logic [OFS-1:0]        in_ofs;
  logic [2:0]            in_ofs3;
  logic [2:0]            align_mask;
  logic [7:0]            size_be;
  logic                  is_load, is_store, illegal, misalign;
  logic [DATA_WIDTH-1:0] shifted, ld_data;

  always_comb begin
    in_ofs   = i_addr[OFS-1:0];
    in_ofs3  = 3'(in_ofs);
    is_load  = (i_opcode == OP_LOAD);
    is_store = (i_opcode == OP_STORE);
    illegal  = 1'b1;
    if (is_load) begin
      case (i_func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        3'b011, 3'b110:                         illegal = !WIDE;
        default:                                illegal = 1'b1;
      endcase
    end else if (is_store) begin
      case (i_func3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        3'b011:                 illegal = !WIDE;
        default:                illegal = 1'b1;
      endcase
    end
    case (i_func3[1:0])
      2'd0:    begin align_mask = 3'b000; size_be = 8'h01; end
      2'd1:    begin align_mask = 3'b001; size_be = 8'h03; end
      2'd2:    begin align_mask = 3'b011; size_be = 8'h0F; end
      default: begin align_mask = 3'b111; size_be = 8'hFF; end
    endcase
    misalign = (in_ofs3 & align_mask) != 3'b000;
  end

  // Load data is extracted combinationally from the bus word in the WAIT cycle.
  always_comb begin
    shifted = i_mem_rdata >> {ofs_q, 3'b000};
    case (func3_q)
      3'b000:  ld_data = DATA_WIDTH'($signed(shifted[7:0]));
      3'b001:  ld_data = DATA_WIDTH'($signed(shifted[15:0]));
      3'b010:  ld_data = DATA_WIDTH'($signed(shifted[31:0]));
      3'b100:  ld_data = DATA_WIDTH'(shifted[7:0]);
      3'b101:  ld_data = DATA_WIDTH'(shifted[15:0]);
      3'b110:  ld_data = DATA_WIDTH'(shifted[31:0]);
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    func3_d   = func3_q;
    ofs_d     = ofs_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_mis_d = err_mis_q;
    err_bus_d = err_bus_q;
    err_ill_d = err_ill_q;
    tmo_d     = tmo_q;
    if ((state_q == S_REQ || state_q == S_WAIT) && tmo_q != 8'd0) begin
      tmo_d = tmo_q - 8'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          func3_d   = i_func3;
          ofs_d     = in_ofs;
          we_d      = is_store;
          addr_d    = {i_addr[ADDR_WIDTH-1:OFS], OFS'(0)};
          be_d      = is_store ? NB'({8'h00, size_be} << in_ofs3) : '1;
          wdata_d   = i_wdata << {in_ofs, 3'b000};
          tmo_d     = 8'(TIMEOUT - 1);
          err_ill_d = illegal;
          err_mis_d = !illegal && misalign;
          err_bus_d = 1'b0;
          if (illegal || misalign) begin
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (i_mem_gnt) begin
          state_d = we_q ? S_RESP : S_WAIT;
        end else if (tmo_q == 8'd0) begin
          err_bus_d = 1'b1;
          rdata_d   = '0;
          state_d   = S_RESP;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end else if (tmo_q == 8'd0) begin
          err_bus_d = 1'b1;
          rdata_d   = '0;
          state_d   = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      func3_q   <= '0;
      ofs_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_mis_q <= 1'b0;
      err_bus_q <= 1'b0;
      err_ill_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      func3_q   <= func3_d;
      ofs_q     <= ofs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_mis_q <= err_mis_d;
      err_bus_q <= err_bus_d;
      err_ill_q <= err_ill_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_ready        = (state_q == S_IDLE) && !i_rst;
  assign o_mem_req      = (state_q == S_REQ);
  assign o_mem_we       = we_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_be       = be_q;
  assign o_mem_wdata    = wdata_q;
  assign o_rsp_valid    = (state_q == S_RESP);
  assign o_rdata        = rdata_q;
  assign o_err_misalign = o_rsp_valid && err_mis_q;
  assign o_err_bus      = o_rsp_valid && err_bus_q;
  assign o_err_illegal  = o_rsp_valid && err_ill_q;
endmodule
